vi_frame_sync: RTL



---
 rtl/vi_pkg.sv | 13 +
 rtl/vi_edge_sync.sv | 55 +++++
 rtl/vi_frame_sync.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/vi_pkg.sv
// Shared types and constants for the VI frame-sync receiver.
package vi_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } vi_state_t;

    localparam int VI_PULSES_PER_FRAME = 40;
    localparam int VI_SLOT_W           = 6;

endpackage

// File: rtl/vi_edge_sync.sv
// iVI conditioning: 2-FF synchronizer, optional 2-sample glitch filter
// (VI_GLITCH_FILTER_EN) and a rising-edge strobe to the decoder.
module vi_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_vi,
    output logic o_edge
);

    logic r_sync1;
    logic r_sync2;
    logic r_level;
    logic w_level;

`ifdef VI_GLITCH_FILTER_EN
    logic r_sync3;

    // Delayed copy of the synchronized level, so two consecutive samples can be compared
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync3 <= 1'b0;
        end else begin
            r_sync3 <= r_sync2;
        end
    end

    // Level changes only once two consecutive samples agree
    always_comb begin
        if (r_sync2 == r_sync3) begin
            w_level = r_sync2;
        end else begin
            w_level = r_level;
        end
    end
`else
    always_comb begin
        w_level = r_sync2;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= i_vi;
            r_sync2 <= r_sync1;
            r_level <= w_level;
        end
    end

    assign o_edge = w_level & ~r_level;

endmodule

// File: rtl/vi_frame_sync.sv
// VI frame-sync receiver: measures pulse spacing, treats an overlong interval as the
// frame marker, tracks slot index and lock. Optional input filter: VI_GLITCH_FILTER_EN.
module vi_frame_sync
    import vi_pkg::*;
#(
    parameter int PULSES_PER_FRAME = VI_PULSES_PER_FRAME,
    parameter int CNT_W            = 16,
    parameter int LOCK_FRAMES      = 2,
    parameter int TIMEOUT_CYC      = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iVI,
    output logic                 oPulse,
    output logic                 oFrame,
    output logic [VI_SLOT_W-1:0] oSlot,
    output logic                 oLocked,
    output logic                 oErr
);

    localparam int                   GOOD_W    = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [VI_SLOT_W-1:0] LAST_SLOT = VI_SLOT_W'(PULSES_PER_FRAME - 2);
    localparam logic [CNT_W-1:0]     TMO_VAL   = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]     IVL_MAX   = {CNT_W{1'b1}};
    localparam logic [GOOD_W-1:0]    GOOD_LOCK = GOOD_W'(LOCK_FRAMES);

    logic                 w_edge, w_gap, w_norm, w_tmo, w_last, w_err, w_frame;
    logic [CNT_W:0]       w_thresh;
    vi_state_t            r_state, w_state_nxt;
    logic [GOOD_W-1:0]    r_good, w_good_nxt, w_good_inc;
    logic [CNT_W-1:0]     r_ivl, r_nom;
    logic [VI_SLOT_W-1:0] r_slot;
    logic                 r_pulse, r_frame, r_locked, r_err;

    vi_edge_sync u_edge (
        .clk    (clk),
        .rst    (rst),
        .i_vi   (iVI),
        .o_edge (w_edge)
    );

    // Gap threshold is 1.5x the nominal period, one bit wider so it cannot wrap
    assign w_thresh   = {1'b0, r_nom} + {2'b00, r_nom[CNT_W-1:1]};
    assign w_gap      = w_edge & (r_nom != {CNT_W{1'b0}}) & ({1'b0, r_ivl} > w_thresh);
    assign w_norm     = w_edge & ~w_gap;
    assign w_tmo      = ~w_edge & (r_ivl == TMO_VAL);
    assign w_last     = (r_slot == LAST_SLOT);
    assign w_good_inc = r_good + GOOD_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEARCH;
            r_good  <= {GOOD_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_good  <= w_good_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        if (w_tmo) begin
            w_state_nxt = SEARCH;
            w_good_nxt  = {GOOD_W{1'b0}};
        end else if (w_gap) begin
            case (r_state)
                SEARCH: begin
                    w_state_nxt = VERIFY;
                    w_good_nxt  = {GOOD_W{1'b0}};
                end
                VERIFY, LOCKED: begin
                    if (!w_last) begin
                        w_state_nxt = VERIFY;
                        w_good_nxt  = {GOOD_W{1'b0}};
                    end else if (r_state == VERIFY) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc >= GOOD_LOCK) begin
                            w_state_nxt = LOCKED;
                        end else begin
                            w_state_nxt = VERIFY;
                        end
                    end else begin
                        w_state_nxt = LOCKED;
                    end
                end
                default: begin
                    w_state_nxt = SEARCH;
                    w_good_nxt  = {GOOD_W{1'b0}};
                end
            endcase
        end else if (w_norm && w_last && (r_state != SEARCH)) begin
            // Expected gap did not arrive
            w_state_nxt = SEARCH;
            w_good_nxt  = {GOOD_W{1'b0}};
        end else begin
            w_state_nxt = r_state;
        end
    end

    always_comb begin
        w_err   = 1'b0;
        w_frame = 1'b0;
        if (w_tmo) begin
            w_err = 1'b1;
        end else if (r_state != SEARCH) begin
            if (w_gap) begin
                w_err   = ~w_last;
                w_frame = w_last & (w_state_nxt == LOCKED);
            end else if (w_norm && w_last) begin
                w_err = 1'b1;
            end else begin
                w_err = 1'b0;
            end
        end else begin
            w_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ivl    <= {CNT_W{1'b0}};
            r_nom    <= {CNT_W{1'b0}};
            r_slot   <= {VI_SLOT_W{1'b0}};
            r_pulse  <= 1'b0;
            r_frame  <= 1'b0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_edge) begin
                r_ivl <= CNT_W'(1);
            end else if (r_ivl != IVL_MAX) begin
                r_ivl <= r_ivl + CNT_W'(1);
            end else begin
                r_ivl <= r_ivl;
            end

            if (w_tmo) begin
                r_nom <= {CNT_W{1'b0}};
            end else if (w_norm) begin
                r_nom <= r_ivl;
            end else begin
                r_nom <= r_nom;
            end

            if (w_gap) begin
                r_slot <= {VI_SLOT_W{1'b0}};
            end else if (w_edge) begin
                r_slot <= r_slot + VI_SLOT_W'(1);
            end else begin
                r_slot <= r_slot;
            end

            r_pulse  <= w_edge;
            r_frame  <= w_frame;
            r_err    <= w_err;
            r_locked <= (r_state == LOCKED);
        end
    end

    assign oPulse  = r_pulse;
    assign oFrame  = r_frame;
    assign oSlot   = r_slot;
    assign oLocked = r_locked;
    assign oErr    = r_err;

endmodule
